// File: rtl/pmp_serial_checker.sv
// Serial PMP checker: walks PMP entries one per cycle, stops at the first
// overlapping region and returns an allow/deny decision over valid/ready.

module tor (
  input  logic [31:0] addr_n_1,
  input  logic [31:0] addr_n,
  input  logic [32:0] acc_lo,
  input  logic [32:0] acc_hi,
  output logic        full,
  output logic        partial
);
  logic [32:0] lo, hi;
  logic        nonempty, overlap;

  assign lo       = {1'b0, addr_n_1};
  assign hi       = {1'b0, addr_n};
  assign nonempty = lo < hi;
  assign full     = nonempty && (acc_lo >= lo) && (acc_hi <= hi);
  assign overlap  = nonempty && (acc_lo < hi) && (acc_hi > lo);
  assign partial  = overlap && !full;
endmodule

module pmp_serial_checker #(
  parameter int NUM_ENTRIES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  input  logic [1:0]               req_size,
  input  logic [1:0]               req_type,
  input  logic                     req_priv,
  input  logic [8*NUM_ENTRIES-1:0] pmpcfg_i,
  input  logic [32*NUM_ENTRIES-1:0] pmpaddr_i,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic                     resp_allow,
  output logic                     resp_hit,
  output logic [3:0]               resp_idx
);
  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;
  typedef enum logic [1:0] {A_OFF, A_TOR, A_NA4, A_NAPOT} amode_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [1:0]  kind;
    logic        priv;
  } req_t;

  state_t      state;
  req_t        req_q;
  logic [3:0]  k;
  logic        issue_done;

  // Evaluation stage: entry k is matched and registered, then acted on a cycle later.
  logic        ev_vld, ev_full, ev_part, ev_allow, ev_last;
  logic [3:0]  ev_idx;

  logic [7:0]  cfg_arr   [NUM_ENTRIES];
  logic [31:0] raw_arr   [NUM_ENTRIES];
  logic [31:0] base_arr  [NUM_ENTRIES];
  logic [31:0] base_prev [NUM_ENTRIES];

  for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_ent
    assign cfg_arr[g]  = pmpcfg_i[8*g +: 8];
    assign raw_arr[g]  = pmpaddr_i[32*g +: 32];
    assign base_arr[g] = {pmpaddr_i[32*g +: 30], 2'b00};
    if (g == 0) begin : g_first
      assign base_prev[g] = '0;
    end else begin : g_rest
      assign base_prev[g] = {pmpaddr_i[32*(g-1) +: 30], 2'b00};
    end
  end

  logic [7:0]  cur_cfg;
  logic [31:0] cur_raw, cur_base, cur_prev;
  amode_t      cur_mode;
  logic        unused_cfg;

  assign cur_cfg    = cfg_arr[k];
  assign cur_raw    = raw_arr[k];
  assign cur_base   = base_arr[k];
  assign cur_prev   = base_prev[k];
  assign cur_mode   = amode_t'(cur_cfg[4:3]);
  assign unused_cfg = ^cur_cfg[6:5];

  logic [32:0] acc_lo, acc_hi;
  assign acc_lo = {1'b0, req_q.addr};
  assign acc_hi = acc_lo + (33'd1 << req_q.size);

  logic tor_full, tor_part;

  tor u_tor (
    .addr_n_1 (cur_prev),
    .addr_n   (cur_base),
    .acc_lo   (acc_lo),
    .acc_hi   (acc_hi),
    .full     (tor_full),
    .partial  (tor_part)
  );

  logic [5:0]  t1;
  logic [32:0] napot_sz, loc_lo, loc_hi;
  logic        loc_full, loc_part;

  always_comb begin
    t1 = '0;
    for (int i = 0; i < 32; i++)
      if (cur_raw[i] && t1 == 6'(i)) t1 = t1 + 6'd1;
  end

  always_comb begin
    napot_sz = '0;
    loc_lo   = '0;
    loc_hi   = '0;
    if (cur_mode == A_NA4) begin
      loc_lo = {1'b0, cur_base};
      loc_hi = loc_lo + 33'd4;
    end else if (cur_mode == A_NAPOT) begin
      // 29+ trailing ones spans at least 4 GiB: the whole address space.
      if (t1 >= 6'd29) begin
        loc_lo = '0;
        loc_hi = 33'h1_0000_0000;
      end else begin
        napot_sz = 33'd1 << (t1 + 6'd3);
        loc_lo   = {1'b0, cur_base} & ~(napot_sz - 33'd1);
        loc_hi   = loc_lo + napot_sz;
      end
    end
  end

  assign loc_full = (loc_lo < loc_hi) && (acc_lo >= loc_lo) && (acc_hi <= loc_hi);
  assign loc_part = (loc_lo < loc_hi) && (acc_lo < loc_hi) && (acc_hi > loc_lo) && !loc_full;

  logic m_full, m_part, perm, m_allow;

  always_comb begin
    m_full = 1'b0;
    m_part = 1'b0;
    case (cur_mode)
      A_TOR:           begin m_full = tor_full; m_part = tor_part; end
      A_NA4, A_NAPOT:  begin m_full = loc_full; m_part = loc_part; end
      default:         ;
    endcase
  end

  always_comb begin
    case (req_q.kind)
      2'd0:    perm = cur_cfg[0];
      2'd1:    perm = cur_cfg[1];
      2'd2:    perm = cur_cfg[2];
      default: perm = 1'b0;
    endcase
  end

  // Unlocked entries never restrict M-mode; partial matches always deny.
  assign m_allow = m_full && ((req_q.priv && !cur_cfg[7]) || perm);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_q      <= '0;
      k          <= '0;
      issue_done <= 1'b0;
      ev_vld     <= 1'b0;
      ev_full    <= 1'b0;
      ev_part    <= 1'b0;
      ev_allow   <= 1'b0;
      ev_last    <= 1'b0;
      ev_idx     <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_allow <= 1'b0;
      resp_hit   <= 1'b0;
      resp_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_q      <= '{addr: req_addr, size: req_size, kind: req_type, priv: req_priv};
            k          <= '0;
            issue_done <= 1'b0;
            ev_vld     <= 1'b0;
            req_ready  <= 1'b0;
            state      <= SCAN;
          end
        end
        SCAN: begin
          if (!issue_done) begin
            ev_vld   <= 1'b1;
            ev_full  <= m_full;
            ev_part  <= m_part;
            ev_allow <= m_allow;
            ev_idx   <= k;
            ev_last  <= (k == 4'(NUM_ENTRIES - 1));
            if (k == 4'(NUM_ENTRIES - 1)) issue_done <= 1'b1;
            else                          k          <= k + 4'd1;
          end else begin
            ev_vld <= 1'b0;
          end
          // Entry k+1 is already in flight when a hit at k lands; it is dropped.
          if (ev_vld && (ev_full || ev_part)) begin
            resp_valid <= 1'b1;
            resp_hit   <= 1'b1;
            resp_allow <= ev_allow;
            resp_idx   <= ev_idx;
            state      <= RESP;
          end else if (ev_vld && ev_last) begin
            resp_valid <= 1'b1;
            resp_hit   <= 1'b0;
            resp_allow <= req_q.priv;
            resp_idx   <= '0;
            state      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
